adsr_phase_sequencer: RTL and testbench
=======================================

# adsr_phase_sequencer

Envelope controller for the synth voice: sequences the Attack/Decay/Sustain/Release phases from a note gate and four pot values (0-1023), producing an 8-bit envelope level that scales the oscillator output. Each ramping phase has its own step rate, derived on-chip from that phase's pot value with a programmable-period step timer. It sits between the pot/ADC front end and the amplitude multiplier.

## Interface
- `LEVEL_W`, 8: envelope level width; the full-scale level is `2^LEVEL_W-1`.
- `RATE_W`, 10: width of the pot inputs.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `gate` in 1: note held; level-sensitive; already synchronous to `clk`.
- `attack_rate` in RATE_W: attack step period minus 1, in clk cycles.
- `decay_rate` in RATE_W: decay step period minus 1.
- `sustain_level` in RATE_W: sustain target; only bits `[9:2]` are used (`s`).
- `release_rate` in RATE_W: release step period minus 1.
- `env_level` out LEVEL_W: current envelope level; registered.
- `phase` out 3: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4; registered.
- `active` out 1: high whenever `phase` is not IDLE; registered.
- `step` out 1: one-cycle pulse on every level increment or decrement; registered.

## Operation
- `gate_q` registers `gate`. A rise is `gate & ~gate_q`; a fall is `~gate & gate_q`.
- The step timer is a RATE_W counter `t`. In ATTACK, DECAY and RELEASE it counts 0..R, where R is the current phase's rate input, sampled live each cycle.
  - When `t == R`: a step happens and `t` returns to 0.
  - The step period is R+1 cycles, so R=0 gives a step every cycle.
  - `t` is cleared on every phase change and held at 0 in IDLE and SUSTAIN.
  - If R drops below `t` mid-count, the comparison is `t >= R`.
- Transitions, in priority order: `rst`, then gate fall, then gate rise, then phase logic.
  - IDLE: rise → ATTACK.
  - ATTACK: if the level is at full scale → DECAY with no step. Otherwise a step adds 1; when the new level reaches full scale → DECAY.
  - DECAY: if `env_level <= s` → SUSTAIN with no step. Otherwise a step subtracts 1; when the new level is `<= s` → SUSTAIN.
  - SUSTAIN: `env_level` is held. A later change to `sustain_level` is ignored until the next DECAY.
  - RELEASE: if the level is 0 → IDLE. Otherwise a step subtracts 1; when the new level is 0 → IDLE.
  - RELEASE: a rise → ATTACK (retrigger, see Configuration).
  - A fall in ATTACK, DECAY or SUSTAIN → RELEASE, starting from the current level.
- Arithmetic: the level never wraps. Increments saturate at full scale and decrements saturate at 0.
- If a gate rise and fall both fall within one pulse, each is handled on the cycle it is detected. A 1-cycle gate pulse therefore gives ATTACK for one cycle, then RELEASE.

## Timing
- Reset values: `env_level`=0, `phase`=IDLE, `active`=0, `step`=0, `t`=0, `gate_q`=0.
- `rst` asserted mid-note forces these values on the next edge, whatever the phase.
- Gate latency: if `gate` is first sampled high at edge N, `phase`=ATTACK is visible after edge N.
- The first attack step occurs at edge N+1+R_attack.
- `step` is high in the cycle in which the new `env_level` is first visible.
- A phase-change decision and the level update it causes land on the same edge.

## Configuration
- `ADSR_HARD_RESTART_EN`
  - Defined: a gate rise in RELEASE clears `env_level` to 0 on the same edge that enters ATTACK.
  - Undefined: the attack restarts from the current release level (legato retrigger).
- IDLE entry behaves identically either way, since the level is already 0.

## Test plan
- Reset: hold `rst` 3 cycles, with `gate` high during reset → all outputs 0 and `phase`=0. ATTACK is entered only after `gate` is seen rising after reset.
- Full cycle: attack=0, decay=3, sustain=512 (s=128), release=1, gate high at cycle 0.
  - Level 255 after 255 steps, 1 cycle apart.
  - DECAY reaches 128 after 127×4 cycles, then SUSTAIN holds.
  - Gate low → 128 steps, 2 cycles apart, to 0, then IDLE with `active`=0.
- Sustain ≥ full scale: sustain=1023 → DECAY lasts exactly 1 cycle, then SUSTAIN at 255 with no `step` pulse.
- Early release: attack=9, gate low after 55 cycles.
  - Level 5 when the fall is detected.
  - RELEASE ramps down from 5; no DECAY occurs.
- Retrigger: gate high again while RELEASE is at level 60.
  - Legato: ATTACK resumes from 60.
  - With `ADSR_HARD_RESTART_EN`: level 0 on entry, then ramps up.
- Live rate change: decay_rate goes 1000→0 while `t`=500 → a step on the next edge, then a step every cycle thereafter.

Source files
------------

// File: rtl/adsr_phase_sequencer.sv
// ADSR envelope sequencer: gate-driven Attack/Decay/Sustain/Release phases with per-phase step timer.
// Optional build macro ADSR_HARD_RESTART_EN: a retrigger during RELEASE restarts the attack from level 0.
module adsr_phase_sequencer #(
    parameter int LEVEL_W = 8,
    parameter int RATE_W  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               gate,
    input  logic [RATE_W-1:0]  attack_rate,
    input  logic [RATE_W-1:0]  decay_rate,
    input  logic [RATE_W-1:0]  sustain_level,
    input  logic [RATE_W-1:0]  release_rate,
    output logic [LEVEL_W-1:0] env_level,
    output logic [2:0]         phase,
    output logic               active,
    output logic               step
);

    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_ATTACK  = 3'd1,
        PH_DECAY   = 3'd2,
        PH_SUSTAIN = 3'd3,
        PH_RELEASE = 3'd4
    } phase_e;

    localparam logic [LEVEL_W-1:0] LEVEL_FULL = {LEVEL_W{1'b1}};
    localparam logic [LEVEL_W-1:0] LEVEL_ZERO = {LEVEL_W{1'b0}};
    localparam logic [RATE_W-1:0]  T_ZERO     = {RATE_W{1'b0}};

    function automatic logic [LEVEL_W-1:0] sat_inc(input logic [LEVEL_W-1:0] v);
        sat_inc = (v == LEVEL_FULL) ? LEVEL_FULL : v + LEVEL_W'(1);
    endfunction

    function automatic logic [LEVEL_W-1:0] sat_dec(input logic [LEVEL_W-1:0] v);
        sat_dec = (v == LEVEL_ZERO) ? LEVEL_ZERO : v - LEVEL_W'(1);
    endfunction

    phase_e             phase_q, phase_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [RATE_W-1:0]  t_q, t_d;
    logic               step_q, step_d;
    logic               active_q;
    logic               gate_q;

    logic               rise_s;
    logic               fall_s;
    logic [RATE_W-1:0]  rate_s;
    logic               tick_s;
    logic [LEVEL_W-1:0] sus_s;
    logic [LEVEL_W-1:0] up_s;
    logic [LEVEL_W-1:0] down_s;
    logic               unused_s;

    assign rise_s   = gate & ~gate_q;
    assign fall_s   = ~gate & gate_q;
    assign sus_s    = sustain_level[RATE_W-1 -: LEVEL_W];
    assign unused_s = ^sustain_level[RATE_W-LEVEL_W-1:0];
    assign up_s     = sat_inc(level_q);
    assign down_s   = sat_dec(level_q);
    // Live rate compare with >= so a rate lowered below the running count fires immediately.
    assign tick_s   = (t_q >= rate_s);

    // Select the step period of the phase currently ramping.
    always_comb begin
        rate_s = T_ZERO;
        case (phase_q)
            PH_ATTACK:  rate_s = attack_rate;
            PH_DECAY:   rate_s = decay_rate;
            PH_RELEASE: rate_s = release_rate;
            default:    rate_s = T_ZERO;
        endcase
    end

    // Next-state logic: gate fall beats gate rise, both beat the per-phase ramp.
    always_comb begin
        phase_d = phase_q;
        level_d = level_q;
        t_d     = t_q;
        step_d  = 1'b0;
        if (fall_s && (phase_q == PH_ATTACK || phase_q == PH_DECAY || phase_q == PH_SUSTAIN)) begin
            phase_d = PH_RELEASE;
            t_d     = T_ZERO;
        end else if (rise_s && (phase_q == PH_IDLE || phase_q == PH_RELEASE)) begin
            phase_d = PH_ATTACK;
            t_d     = T_ZERO;
`ifdef ADSR_HARD_RESTART_EN
            level_d = LEVEL_ZERO;
`else
            level_d = level_q;
`endif
        end else begin
            case (phase_q)
                PH_IDLE: begin
                    t_d = T_ZERO;
                end
                PH_ATTACK: begin
                    if (level_q == LEVEL_FULL) begin
                        phase_d = PH_DECAY;
                        t_d     = T_ZERO;
                    end else if (tick_s) begin
                        level_d = up_s;
                        step_d  = 1'b1;
                        t_d     = T_ZERO;
                        if (up_s == LEVEL_FULL) begin
                            phase_d = PH_DECAY;
                        end else begin
                            phase_d = PH_ATTACK;
                        end
                    end else begin
                        t_d = t_q + RATE_W'(1);
                    end
                end
                PH_DECAY: begin
                    if (level_q <= sus_s) begin
                        phase_d = PH_SUSTAIN;
                        t_d     = T_ZERO;
                    end else if (tick_s) begin
                        level_d = down_s;
                        step_d  = 1'b1;
                        t_d     = T_ZERO;
                        if (down_s <= sus_s) begin
                            phase_d = PH_SUSTAIN;
                        end else begin
                            phase_d = PH_DECAY;
                        end
                    end else begin
                        t_d = t_q + RATE_W'(1);
                    end
                end
                PH_SUSTAIN: begin
                    t_d = T_ZERO;
                end
                PH_RELEASE: begin
                    if (level_q == LEVEL_ZERO) begin
                        phase_d = PH_IDLE;
                        t_d     = T_ZERO;
                    end else if (tick_s) begin
                        level_d = down_s;
                        step_d  = 1'b1;
                        t_d     = T_ZERO;
                        if (down_s == LEVEL_ZERO) begin
                            phase_d = PH_IDLE;
                        end else begin
                            phase_d = PH_RELEASE;
                        end
                    end else begin
                        t_d = t_q + RATE_W'(1);
                    end
                end
                default: begin
                    // Unreachable encodings recover to a silent idle voice.
                    phase_d = PH_IDLE;
                    level_d = LEVEL_ZERO;
                    t_d     = T_ZERO;
                end
            endcase
        end
    end

    // State, level, timer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= PH_IDLE;
            level_q  <= LEVEL_ZERO;
            t_q      <= T_ZERO;
            step_q   <= 1'b0;
            active_q <= 1'b0;
            gate_q   <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            level_q  <= level_d;
            t_q      <= t_d;
            step_q   <= step_d;
            active_q <= (phase_d != PH_IDLE);
            gate_q   <= gate;
        end
    end

    assign env_level = level_q;
    assign phase     = phase_q;
    assign active    = active_q;
    assign step      = step_q;

endmodule

// File: tb/tb_adsr_phase_sequencer.sv
// Directed bench for adsr_phase_sequencer; expected values are hand-derived edge counts.
module tb_adsr_phase_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       gate;
    logic [9:0] attack_rate;
    logic [9:0] decay_rate;
    logic [9:0] sustain_level;
    logic [9:0] release_rate;
    logic [7:0] env_level;
    logic [2:0] phase;
    logic       active;
    logic       step;

    int checks   = 0;
    int failures = 0;

    adsr_phase_sequencer #(.LEVEL_W(8), .RATE_W(10)) dut (
        .clk           (clk),
        .rst           (rst),
        .gate          (gate),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .sustain_level (sustain_level),
        .release_rate  (release_rate),
        .env_level     (env_level),
        .phase         (phase),
        .active        (active),
        .step          (step)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input int lvl, input int ph, input int act, input int stp);
        check({tag, ".level"},  int'(env_level), lvl);
        check({tag, ".phase"},  int'(phase),     ph);
        check({tag, ".active"}, int'(active),    act);
        check({tag, ".step"},   int'(step),      stp);
    endtask

    int lvl_retrig;
    int lvl_after;
    int cycles;
    int saw_decay;

    initial begin
        rst = 1'b1; gate = 1'b1;
        attack_rate = 10'd0; decay_rate = 10'd0; sustain_level = 10'd0; release_rate = 10'd0;
        repeat (3) tick();
        check_out("reset", 0, 0, 0, 0);
        rst = 1'b0; gate = 1'b0;
        tick();
        check_out("idle_after_reset", 0, 0, 0, 0);

        // Full ADSR cycle
        attack_rate = 10'd0; decay_rate = 10'd3; sustain_level = 10'd512; release_rate = 10'd1;
        gate = 1'b1;
        tick();
        check_out("attack_entry", 0, 1, 1, 0);
        tick();
        check_out("attack_first_step", 1, 1, 1, 1);
        repeat (253) tick();
        check_out("attack_254", 254, 1, 1, 1);
        tick();
        check_out("attack_full", 255, 2, 1, 1);
        repeat (3) tick();
        check_out("decay_wait", 255, 2, 1, 0);
        tick();
        check_out("decay_first_step", 254, 2, 1, 1);
        repeat (504) tick();
        check_out("decay_to_sustain", 128, 3, 1, 1);
        sustain_level = 10'd0;
        repeat (5) tick();
        check_out("sustain_hold", 128, 3, 1, 0);
        gate = 1'b0;
        tick();
        check_out("release_entry", 128, 4, 1, 0);
        tick();
        check_out("release_wait", 128, 4, 1, 0);
        tick();
        check_out("release_first_step", 127, 4, 1, 1);
        repeat (253) tick();
        check_out("release_level1", 1, 4, 1, 0);
        tick();
        check_out("release_to_idle", 0, 0, 0, 1);
        tick();
        check_out("idle_settled", 0, 0, 0, 0);

        // Sustain at or above full scale: one-cycle decay, no step
        attack_rate = 10'd0; sustain_level = 10'd1023;
        gate = 1'b1;
        tick();
        check_out("sfs_attack_entry", 0, 1, 1, 0);
        repeat (255) tick();
        check_out("sfs_full", 255, 2, 1, 1);
        tick();
        check_out("sfs_sustain", 255, 3, 1, 0);

        // Retrigger from release at level 60
        release_rate = 10'd0;
        gate = 1'b0;
        tick();
        check_out("rt_release_entry", 255, 4, 1, 0);
        repeat (195) tick();
        check_out("rt_level60", 60, 4, 1, 1);
        gate = 1'b1;
`ifdef ADSR_HARD_RESTART_EN
        lvl_retrig = 0;
`else
        lvl_retrig = 60;
`endif
        lvl_after = lvl_retrig + 1;
        tick();
        check_out("rt_attack_entry", lvl_retrig, 1, 1, 0);
        tick();
        check_out("rt_attack_step", lvl_after, 1, 1, 1);

        // Reset mid-note with gate held high
        rst = 1'b1;
        tick();
        check_out("midnote_reset", 0, 0, 0, 0);
        repeat (2) tick();
        rst = 1'b0; gate = 1'b0;
        tick();
        check_out("midnote_reset_idle", 0, 0, 0, 0);

        // Early release during attack
        attack_rate = 10'd9; decay_rate = 10'd3; sustain_level = 10'd0; release_rate = 10'd2;
        gate = 1'b1;
        tick();
        check_out("er_attack_entry", 0, 1, 1, 0);
        repeat (9) tick();
        check_out("er_attack_wait", 0, 1, 1, 0);
        tick();
        check_out("er_first_step", 1, 1, 1, 1);
        repeat (40) tick();
        check_out("er_level5", 5, 1, 1, 1);
        repeat (4) tick();
        check_out("er_hold5", 5, 1, 1, 0);
        gate = 1'b0;
        tick();
        check_out("er_release_entry", 5, 4, 1, 0);
        cycles = 0;
        saw_decay = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            cycles++;
            if (phase == 3'd2) saw_decay = 1;
            if (phase == 3'd0) break;
        end
        check("er_idle_phase", int'(phase), 0);
        check("er_idle_level", int'(env_level), 0);
        check("er_release_cycles", cycles, 15);
        check("er_no_decay", saw_decay, 0);

        // One-cycle gate pulse
        attack_rate = 10'd0;
        gate = 1'b1;
        tick();
        check_out("pulse_attack", 0, 1, 1, 0);
        gate = 1'b0;
        tick();
        check_out("pulse_release", 0, 4, 1, 0);
        tick();
        check_out("pulse_idle", 0, 0, 0, 0);

        // Live decay rate change mid-count
        attack_rate = 10'd0; decay_rate = 10'd1000; sustain_level = 10'd0; release_rate = 10'd0;
        gate = 1'b1;
        tick();
        repeat (255) tick();
        check_out("live_decay_entry", 255, 2, 1, 1);
        repeat (500) tick();
        check_out("live_t500", 255, 2, 1, 0);
        decay_rate = 10'd0;
        tick();
        check_out("live_step1", 254, 2, 1, 1);
        tick();
        check_out("live_step2", 253, 2, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
